serial_frame_decoder: RTL and testbench
=======================================

// Module: serial_frame_decoder
// PURPOSE
//  Sits directly downstream of the 9-bit serial receiver and consumes its newdata/data/error outputs.
//  Assembles multidrop frames into commands: one header word (bit8=1: address + register) is
//  followed by NBYTES payload bytes and one checksum byte (bit8=0).
//  Emits a one-cycle command strobe with register number and payload; counts framing/checksum errors.
// PARAMETERS
//  DEV_ADDR  4'h1      device address matched in header[7:4]; header address 4'hF = broadcast, always accepted
//  NBYTES    2         payload bytes per frame, legal range 1..4
//  TIMEOUT   16'd50000 max clk cycles between words of one frame before abort
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous reset, active-high
//  rx_newdata in   1          one-cycle pulse: rx_data/rx_error valid this cycle
//  rx_data    in   9          received word; bit8 = header flag
//  rx_error   in   1          receiver start/stop-bit error for this word
//  cmd_valid  out  1          one-cycle pulse: good frame decoded
//  cmd_reg    out  4          register number (header[3:0]) of last good frame
//  cmd_data   out  8*NBYTES   payload of last good frame; first received byte in MSBs
//  frame_err  out  1          one-cycle pulse: frame aborted/rejected
//  err_cnt    out  8          saturating error counter
//  busy       out  1          1 when not in S_IDLE
// BEHAVIOUR
//  Reset: state=S_IDLE; cmd_valid=0, cmd_reg=0, cmd_data=0, frame_err=0, err_cnt=0, busy=0; timer, byte counter, sum cleared.
//  Input events: a word is sampled only in cycles with rx_newdata=1.
//  States: S_IDLE, S_PAYLOAD, S_CSUM, S_EMIT.
//  S_IDLE:
//   - header (bit8=1) with addr==DEV_ADDR or 4'hF: latch reg number, sum=header[7:0], byte_ctr=0 -> S_PAYLOAD.
//   - header with other address: ignored, no error.
//   - word with bit8=0: ignored, no error.
//   - rx_error=1: ignored, no error counted.
//  S_PAYLOAD:
//   - data word: shift into payload shift register; sum += byte (mod 256); byte_ctr++.
//   - after NBYTES bytes -> S_CSUM.
//  S_CSUM:
//   - data word equal to sum: -> S_EMIT.
//   - otherwise: checksum error.
//  S_EMIT (one cycle): cmd_valid=1; cmd_reg/cmd_data updated in the same cycle -> S_IDLE.
//   Net latency: cmd_valid asserts 2 clk after the checksum word's rx_newdata cycle.
//  Errors (non-idle states only): each error pulses frame_err for 1 cycle, increments err_cnt (saturates at 255)
//   and returns to S_IDLE. Error conditions:
//   - rx_error=1 with rx_newdata.
//   - checksum mismatch.
//   - inter-word timer reaching TIMEOUT.
//  Resync: a header word in S_PAYLOAD or S_CSUM counts as an error (frame_err pulse, err_cnt++) and is then
//   processed as an S_IDLE header in the same cycle, so a matching header restarts a frame.
//  Timer: cleared on every rx_newdata; counts only outside S_IDLE; held at 0 in S_IDLE.
//   rx_newdata and timeout in the same cycle: rx_newdata wins, no timeout.
//  cmd_reg/cmd_data hold their values between good frames; they never change on failed frames.
//  rx_newdata in S_EMIT cannot occur (receiver word time >> 1 clk); if present it is dropped.
//  Reset mid-frame: immediate return to reset values; partial frame discarded.
// TESTING
//  1. Good frame (DEV_ADDR=1, NBYTES=2): 9'h112, 9'h034, 9'h056, 9'h09C
//     -> one cmd_valid, cmd_reg=2, cmd_data=16'h3456, err_cnt=0.
//  2. Bad checksum: 9'h112, 9'h034, 9'h056, 9'h09D
//     -> frame_err pulse, err_cnt=1, no cmd_valid, cmd_data unchanged.
//  3. Foreign / broadcast address: 9'h125 + 3 data words -> nothing.
//     9'h1F5, 9'h001, 9'h002, 9'h0F8 -> cmd_valid, cmd_reg=5, cmd_data=16'h0102.
//  4. Resync: 9'h112, 9'h034, then 9'h113, 9'h0AA, 9'h0BB, 9'h078
//     -> err_cnt=1, then cmd_valid, cmd_reg=3, cmd_data=16'hAABB.
//  5. Timeout/rx_error: header then no word for TIMEOUT cycles -> frame_err, busy=0.
//     Header then word with rx_error=1 -> frame_err. 256 errors -> err_cnt stays 255.
//  6. Reset mid-frame: assert rst after the payload byte
//     -> all outputs 0 immediately; following good frame decodes correctly.

Source files
------------

// File: rtl/serial_frame_decoder.sv
// Purpose : assembles multidrop 9-bit serial frames (header + NBYTES payload + checksum) into commands.
// Latency : cmd_valid pulses 2 clk after the cycle in which the checksum word is presented.
// Backpressure: none; words arrive as rx_newdata pulses and cannot be stalled. A word arriving in S_EMIT is dropped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_newdata/rx_data/rx_error  one word per rx_newdata pulse; rx_data[8] marks a header word
//   cmd_valid                one-cycle pulse for each good frame; cmd_reg/cmd_data change in that cycle
//   cmd_reg, cmd_data        register number and payload of the last good frame (first byte in the MSBs)
//   frame_err                one-cycle pulse for each aborted or rejected frame
//   err_cnt                  saturating count of frame errors
//   busy                     high whenever the decoder is not idle
module serial_frame_decoder #(
    parameter logic [3:0]  DEV_ADDR = 4'h1,
    parameter int          NBYTES   = 2,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_newdata,
    input  logic [8:0]            rx_data,
    input  logic                  rx_error,
    output logic                  cmd_valid,
    output logic [3:0]            cmd_reg,
    output logic [8*NBYTES-1:0]   cmd_data,
    output logic                  frame_err,
    output logic [7:0]            err_cnt,
    output logic                  busy
);

    localparam int W = 8 * NBYTES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CSUM,
        S_EMIT
    } state_t;

    state_t         state;
    logic [3:0]     reg_lat;
    logic [W-1:0]   payload;
    logic [7:0]     sum;
    logic [2:0]     byte_ctr;
    logic [15:0]    timer;

    logic           is_hdr;
    logic           addr_ok;
    logic           hdr_ok;
    logic           last_byte;
    logic           timeout_hit;
    logic [7:0]     sum_next;
    logic [W-1:0]   byte_ext;

    always_comb begin
        is_hdr      = rx_data[8];
        addr_ok     = (rx_data[7:4] == DEV_ADDR) || (rx_data[7:4] == 4'hF);
        hdr_ok      = rx_newdata && !rx_error && is_hdr && addr_ok;
        last_byte   = (byte_ctr == 3'(NBYTES - 1));
        // An arriving word always restarts the inter-word interval, so a
        // timeout is only possible in a cycle without rx_newdata.
        timeout_hit = !rx_newdata && (timer == TIMEOUT - 16'd1);
        sum_next    = sum + rx_data[7:0];
        byte_ext    = W'(rx_data[7:0]);
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            reg_lat   <= '0;
            payload   <= '0;
            sum       <= '0;
            byte_ctr  <= '0;
            timer     <= '0;
            cmd_valid <= 1'b0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    timer <= '0;
                    // Only matching, error-free headers open a frame; everything
                    // else seen while idle is silently discarded.
                    if (hdr_ok) begin
                        reg_lat  <= rx_data[3:0];
                        sum      <= rx_data[7:0];
                        byte_ctr <= '0;
                        payload  <= '0;
                        state    <= S_PAYLOAD;
                        busy     <= 1'b1;
                    end
                end

                S_PAYLOAD, S_CSUM: begin
                    if (rx_newdata) begin
                        timer <= '0;
                        if (rx_error) begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                        end else if (is_hdr) begin
                            // Resync: the partial frame is an error, but the header
                            // itself is treated as if it had arrived while idle.
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            if (addr_ok) begin
                                reg_lat  <= rx_data[3:0];
                                sum      <= rx_data[7:0];
                                byte_ctr <= '0;
                                payload  <= '0;
                                state    <= S_PAYLOAD;
                                busy     <= 1'b1;
                            end else begin
                                state    <= S_IDLE;
                                busy     <= 1'b0;
                            end
                        end else if (state == S_PAYLOAD) begin
                            payload  <= (payload << 8) | byte_ext;
                            sum      <= sum_next;
                            byte_ctr <= byte_ctr + 3'd1;
                            if (last_byte) begin
                                state <= S_CSUM;
                            end
                        end else if (rx_data[7:0] == sum) begin
                            state <= S_EMIT;
                        end else begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        timer     <= '0;
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                S_EMIT: begin
                    // Any word arriving here is dropped; the receiver cannot
                    // deliver two words one clock apart.
                    cmd_valid <= 1'b1;
                    cmd_reg   <= reg_lat;
                    cmd_data  <= payload;
                    timer     <= '0;
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_decoder.sv
module tb_serial_frame_decoder;

    localparam logic [15:0] TMO = 16'd200;

    logic        clk;
    logic        rst;
    logic        rx_newdata;
    logic [8:0]  rx_data;
    logic        rx_error;
    logic        cmd_valid;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int total;
    int bad;
    int vld_cnt;
    int v0;
    int n;

    serial_frame_decoder #(
        .DEV_ADDR (4'h1),
        .NBYTES   (2),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_newdata (rx_newdata),
        .rx_data    (rx_data),
        .rx_error   (rx_error),
        .cmd_valid  (cmd_valid),
        .cmd_reg    (cmd_reg),
        .cmd_data   (cmd_data),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial vld_cnt = 0;
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) vld_cnt = vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle word pulse presented between two falling edges.
    task automatic send(input logic [8:0] w, input logic err);
        @(negedge clk);
        rx_newdata = 1'b1;
        rx_data    = w;
        rx_error   = err;
        @(negedge clk);
        rx_newdata = 1'b0;
        rx_error   = 1'b0;
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
    endtask

    // Sends a four-word frame; returns on the falling edge right after the last word's sampling edge.
    task automatic send_frame(input logic [8:0] w0, input logic [8:0] w1,
                              input logic [8:0] w2, input logic [8:0] w3);
        send(w0, 1'b0); gap();
        send(w1, 1'b0); gap();
        send(w2, 1'b0); gap();
        send(w3, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        rx_newdata = 1'b0;
        rx_data    = '0;
        rx_error   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_cnt",   err_cnt,   0);
        check("rst_busy",      busy,      0);
        check("rst_cmd_data",  cmd_data,  0);
        rst = 1'b0;

        // 1. Good frame, with latency check
        v0 = vld_cnt;
        send_frame(9'h112, 9'h034, 9'h056, 9'h09C);
        check("t1_valid_early", cmd_valid, 0);
        check("t1_busy_emit",   busy,      1);
        @(negedge clk);
        check("t1_valid",    cmd_valid, 1);
        check("t1_reg",      cmd_reg,   4'h2);
        check("t1_data",     cmd_data,  16'h3456);
        @(negedge clk);
        check("t1_valid_1cyc", cmd_valid, 0);
        check("t1_busy_idle",  busy,      0);
        check("t1_err_cnt",    err_cnt,   0);
        check("t1_vld_count",  vld_cnt - v0, 1);

        // 2. Bad checksum
        v0 = vld_cnt;
        send_frame(9'h112, 9'h034, 9'h056, 9'h09D);
        check("t2_frame_err", frame_err, 1);
        check("t2_err_cnt",   err_cnt,   1);
        @(negedge clk);
        check("t2_ferr_1cyc", frame_err, 0);
        gap();
        check("t2_no_valid",  vld_cnt - v0, 0);
        check("t2_data_held", cmd_data, 16'h3456);
        check("t2_reg_held",  cmd_reg,  4'h2);

        // 3. Foreign address ignored, broadcast accepted
        v0 = vld_cnt;
        send(9'h125, 1'b0);
        check("t3_foreign_busy", busy, 0);
        gap();
        send_frame(9'h011, 9'h022, 9'h033, 9'h044);
        gap();
        check("t3_foreign_vld",  vld_cnt - v0, 0);
        check("t3_foreign_err",  err_cnt, 1);
        send_frame(9'h1F5, 9'h001, 9'h002, 9'h0F8);
        @(negedge clk);
        check("t3_bc_valid", cmd_valid, 1);
        check("t3_bc_reg",   cmd_reg,   4'h5);
        check("t3_bc_data",  cmd_data,  16'h0102);

        // 4. Resync on a new header mid-frame
        pulse_reset();
        send(9'h112, 1'b0); gap();
        send(9'h034, 1'b0); gap();
        send(9'h113, 1'b0);
        check("t4_resync_ferr", frame_err, 1);
        check("t4_resync_cnt",  err_cnt,   1);
        check("t4_resync_busy", busy,      1);
        gap();
        send(9'h0AA, 1'b0); gap();
        send(9'h0BB, 1'b0); gap();
        send(9'h078, 1'b0);
        @(negedge clk);
        check("t4_valid", cmd_valid, 1);
        check("t4_reg",   cmd_reg,   4'h3);
        check("t4_data",  cmd_data,  16'hAABB);
        check("t4_err_cnt", err_cnt, 1);

        // 5. Timeout, rx_error, saturation
        pulse_reset();
        send(9'h112, 1'b0);
        n = 0;
        for (int i = 1; i <= int'(TMO) + 20; i++) begin
            if (n == 0) begin
                @(posedge clk); #1;
                if (frame_err === 1'b1) n = i;
            end
        end
        check("t5_timeout_seen", (n != 0), 1);
        check("t5_timeout_lat", (n >= int'(TMO) - 1 && n <= int'(TMO) + 1), 1);
        @(negedge clk);
        check("t5_timeout_busy", busy,    0);
        check("t5_timeout_cnt",  err_cnt, 1);

        send(9'h112, 1'b1);
        check("t5_idle_rxerr_busy", busy,    0);
        check("t5_idle_rxerr_cnt",  err_cnt, 1);
        gap();
        send(9'h112, 1'b0); gap();
        send(9'h034, 1'b1);
        check("t5_rxerr_ferr", frame_err, 1);
        check("t5_rxerr_cnt",  err_cnt,   2);
        check("t5_rxerr_busy", busy,      0);
        for (int i = 0; i < 260; i++) begin
            send(9'h112, 1'b0);
            send(9'h034, 1'b1);
        end
        gap();
        check("t5_sat_cnt", err_cnt, 8'hFF);

        // 6. Reset mid-frame
        send_frame(9'h112, 9'h034, 9'h056, 9'h09C);
        @(negedge clk);
        check("t6_pre_data", cmd_data, 16'h3456);
        gap();
        send(9'h112, 1'b0); gap();
        send(9'h034, 1'b0);
        check("t6_mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",  busy,     0);
        check("t6_rst_cnt",   err_cnt,  0);
        check("t6_rst_reg",   cmd_reg,  0);
        check("t6_rst_data",  cmd_data, 0);
        check("t6_rst_valid", cmd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(9'h1F5, 9'h001, 9'h002, 9'h0F8);
        @(negedge clk);
        check("t6_post_valid", cmd_valid, 1);
        check("t6_post_reg",   cmd_reg,   4'h5);
        check("t6_post_data",  cmd_data,  16'h0102);
        check("t6_post_cnt",   err_cnt,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
